uart_tx_fifo_param: RTL and testbench
=====================================

Name: uart_tx_fifo_param

Overview:
- Parametrised successor to the fixed 8N1 UART transmitter.
- Adds a runtime baud divisor, 5–8 data bits, optional even/odd parity, 1 or 2 stop bits, and a TX FIFO with a valid/ready write port.
- Sits behind the APB bridge. Config fields come from the control register; the TX data register write drives wr_valid.

Parameters:
- DIV_W, 16, width of the baud divisor.
- DATA_W, 8, FIFO entry width. Must be >= 8.
- DEPTH, 4, FIFO depth in entries. Must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- baud_div  in  DIV_W  bit period = baud_div+1 clocks.
- data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- parity_en  in  1  append a parity bit.
- parity_odd  in  1  1=odd parity, 0=even parity.
- stop2  in  1  1=two stop bits, 0=one.
- tx_en  in  1  permit new frames to start.
- wr_valid  in  1  write request.
- wr_data  in  DATA_W  byte to queue; only the low data_bits+5 bits are sent.
- wr_ready  out  1  = !fifo_full.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- TX  out  1  serial line, registered, idles high.
- busy  out  1  high from start bit until the end of the last stop bit.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst=1 at a clk edge):
  - TX=1, busy=0, done=0, fifo_count=0, wr_ready=1.
  - FIFO flushed; FSM returns to IDLE.
  - Applies mid-frame too: TX=1 from the next cycle. No done or partial stop bit is produced.
- FIFO write: accepted on an edge where wr_valid && wr_ready.
  - A write while full is dropped; the same-cycle pop is not considered.
  - Simultaneous write and pop: count is unchanged.
  - Write at count 0: accepted. No pop that cycle, since the FIFO is empty.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on an edge where tx_en && count>0:
    - pop the head entry;
    - latch data, data_bits, parity_en, parity_odd, stop2 and baud_div;
    - TX<=0, busy<=1, load the bit-period counter.
  - Config input changes mid-frame have no effect until the next frame.
  - Each state holds for baud_div+1 clocks.
  - START -> DATA:
    - data is sent LSB first;
    - the bit counter runs 0..data_bits+4;
    - unused upper bits are ignored.
  - DATA -> PARITY if parity_en, else -> STOP.
    - Even parity = XOR of the sent data bits; odd parity = its inverse.
  - STOP holds TX=1 for 1 or 2 bit periods.
- At the end of the last stop period:
  - done=1 for one cycle;
  - if tx_en && count>0, pop and go directly to START (TX<=0 that same edge, busy stays 1, no idle gap);
  - otherwise go to IDLE with busy<=0.
- Timing: a write accepted at edge k with the FSM in IDLE and tx_en=1 gives count=1 after k and TX=0 after edge k+1.
- Frame length = (1 + N + P + S) × (baud_div+1) clocks, where N = data bits, P = 1 if parity_en else 0, S = stop bits.
- tx_en falling mid-frame: the current frame completes normally, then the FSM goes to IDLE. FIFO contents are retained.
- baud_div=0 is legal: one clock per bit.
- The bit-period counter counts down to 0, then reloads.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum;
  - data_bits encodings;
  - a function: parity(data, nbits, odd).
- Sub-module uart_sync_fifo (DATA_W, DEPTH): pointers carry one extra wrap bit, full/empty are derived from the pointers, and it outputs count.
- The FSM and shifter stay in the top module.

Test Plan:
- Settings: DEPTH=4, baud_div=3 (4 clk/bit) unless stated otherwise.
- 8N1, write 0xA5 -> TX bits 0,1,0,1,0,0,1,0,1,1, each 4 clocks. done pulses once after 40 clocks; busy is high for exactly 40 clocks.
- 7 data bits, even parity, 2 stop bits, write 0x35 -> TX bits 0,1,0,1,0,1,1,0,0(parity),1,1. Frame lasts 44 clocks; bit 7 of the data is not sent.
- 5 data bits, odd parity, 1 stop bit, write 0x1F -> data 1,1,1,1,1, parity 0. Then change data_bits mid-frame -> that frame is still 5 bits.
- tx_en=0, write 0x11, 0x22, 0x33, 0x44, 0x55 -> the first four are accepted, wr_ready=0 at count=4, and 0x55 is dropped. Then set tx_en=1 -> four frames back-to-back with no idle cycle between stop and start; done pulses 4 times; count decrements at each start.
- Assert rst at clock 15 of a 0xA5 frame -> TX=1 the next cycle, count=0, no done. A subsequent write of 0x3C is transmitted correctly.
- baud_div=0, write 0x81 -> 10-clock frame with TX bits 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter:
// FSM state encoding, data_bits codes and the parity function.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [1:0] DB_5 = 2'b00;
    localparam logic [1:0] DB_6 = 2'b01;
    localparam logic [1:0] DB_7 = 2'b10;
    localparam logic [1:0] DB_8 = 2'b11;

    function automatic logic [3:0] nbits_of(input logic [1:0] code);
        logic [3:0] n;
        case (code)
            DB_5:    n = 4'd5;
            DB_6:    n = 4'd6;
            DB_7:    n = 4'd7;
            DB_8:    n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // XOR over the bits actually sent; odd parity is the inverse.
    function automatic logic parity(input logic [7:0] data, input logic [1:0] nbits,
                                    input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(nbits_of(nbits))) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit so full/empty/count
// fall out of pointer arithmetic.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_en_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic                      rd_en_i,
    output logic [DATA_W-1:0]         rd_data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, rptr_q;
    logic              wr_fire, rd_fire;

    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o   = (wptr_q == rptr_q);
    assign count_o   = wptr_q - rptr_q;
    assign rd_data_o = mem_q[rptr_q[AW-1:0]];
    assign wr_fire   = wr_en_i && !full_o;
    assign rd_fire   = rd_en_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_fire) wptr_q <= wptr_q + 1'b1;
            if (rd_fire) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with runtime baud divisor, 5-8 data bits, optional
// parity, 1/2 stop bits, fed from a small TX FIFO.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DIV_W-1:0]       baud_div_i,
    input  logic [1:0]             data_bits_i,
    input  logic                   parity_en_i,
    input  logic                   parity_odd_i,
    input  logic                   stop2_i,
    input  logic                   tx_en_i,
    input  logic                   wr_valid_i,
    input  logic [DATA_W-1:0]      wr_data_i,
    output logic                   wr_ready_o,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   done_o
);
    logic              empty, full, pop, load, cnt_zero;
    logic [DATA_W-1:0] rd_data;
    logic [2:0]        last_bit;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        db_q, db_d;
    logic              par_en_q, par_en_d, par_q, par_d, stop_left_q, stop_left_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d;

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_valid_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (pop),
        .rd_data_o (rd_data),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (fifo_count_o)
    );

    assign wr_ready_o = !full;
    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign cnt_zero   = (cnt_q == '0);
    assign last_bit   = 3'(nbits_of(db_q) - 4'd1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_d       = bit_q;
        db_d        = db_q;
        par_en_d    = par_en_q;
        par_d       = par_q;
        stop_left_d = stop_left_q;
        sh_d        = sh_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;
        pop         = 1'b0;
        if (state_q != S_IDLE && !cnt_zero) cnt_d = cnt_q - 1'b1;
        case (state_q)
            S_IDLE: load = tx_en_i && !empty;
            S_START: if (cnt_zero) begin
                state_d = S_DATA;
                cnt_d   = div_q;
                bit_d   = '0;
                tx_d    = sh_q[0];
                sh_d    = sh_q >> 1;
            end
            S_DATA: if (cnt_zero) begin
                cnt_d = div_q;
                if (bit_q == last_bit) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                    tx_d    = par_en_q ? par_q : 1'b1;
                end else begin
                    bit_d = bit_q + 1'b1;
                    tx_d  = sh_q[0];
                    sh_d  = sh_q >> 1;
                end
            end
            S_PARITY: if (cnt_zero) begin
                state_d = S_STOP;
                cnt_d   = div_q;
                tx_d    = 1'b1;
            end
            S_STOP: if (cnt_zero) begin
                if (stop_left_q) begin
                    stop_left_d = 1'b0;
                    cnt_d       = div_q;
                end else begin
                    done_d = 1'b1;
                    load   = tx_en_i && !empty;
                    if (!load) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Frame start: config is snapshotted so mid-frame changes are ignored.
        if (load) begin
            pop         = 1'b1;
            state_d     = S_START;
            cnt_d       = baud_div_i;
            div_d       = baud_div_i;
            db_d        = data_bits_i;
            par_en_d    = parity_en_i;
            par_d       = parity(rd_data[7:0], data_bits_i, parity_odd_i);
            stop_left_d = stop2_i;
            sh_d        = rd_data;
            tx_d        = 1'b0;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            db_q        <= DB_8;
            par_en_q    <= 1'b0;
            par_q       <= 1'b0;
            stop_left_q <= 1'b0;
            sh_q        <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            db_q        <= db_d;
            par_en_q    <= par_en_d;
            par_q       <= par_d;
            stop_left_q <= stop_left_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: frame shapes, FIFO full/drop,
// back-to-back frames, mid-frame reset and baud_div=0.
module tb_uart_tx_fifo_param;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [1:0]  data_bits;
    logic        parity_en, parity_odd, stop2, tx_en, wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready, tx, busy, done;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo_param #(.DIV_W(16), .DATA_W(8), .DEPTH(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .baud_div_i   (baud_div),
        .data_bits_i  (data_bits),
        .parity_en_i  (parity_en),
        .parity_odd_i (parity_odd),
        .stop2_i      (stop2),
        .tx_en_i      (tx_en),
        .wr_valid_i   (wr_valid),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .fifo_count_o (fifo_count),
        .tx_o         (tx),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    // Monitor: records TX during busy cycles, done pulses and their timing.
    logic mon_clr = 1'b1;
    logic txq[$];
    int   dcount_q[$];
    int   cyc = 0, first_busy = -1, last_done = -1, done_cnt = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_clr) begin
            txq.delete();
            dcount_q.delete();
            first_busy = -1;
            last_done  = -1;
            done_cnt   = 0;
        end else begin
            if (busy) begin
                txq.push_back(tx);
                if (first_busy < 0) first_busy = cyc;
            end
            if (done) begin
                done_cnt++;
                last_done = cyc;
                dcount_q.push_back(int'(fifo_count));
            end
        end
    end

    task automatic clr_mon();
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic cfg(input logic [15:0] bd, input logic [1:0] db, input logic pe,
                       input logic po, input logic s2);
        baud_div = bd; data_bits = db; parity_en = pe; parity_odd = po; stop2 = s2;
    endtask

    task automatic write(input logic [7:0] d);
        @(negedge clk); wr_valid = 1'b1; wr_data = d;
        @(negedge clk); wr_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, output bit timed_out);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            @(negedge clk); k++;
        end
        timed_out = (done_cnt < n);
    endtask

    // Number of positions where the captured line differs from the
    // expected bit string (first-sent bit at index n-1), plus length error.
    function automatic int seq_diff(input logic [63:0] bits, input int n, input int bl);
        int d = 0, sz;
        sz = n * bl;
        d = (txq.size() > sz) ? txq.size() - sz : sz - txq.size();
        for (int i = 0; i < n; i++)
            for (int j = 0; j < bl; j++)
                if (i * bl + j < txq.size() && txq[i * bl + j] !== bits[n - 1 - i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({tx, busy, done, wr_ready} !== 4'b1001 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset tx/busy/done/ready=%b count=%0d exp 1001 count 0",
                     {tx, busy, done, wr_ready}, fifo_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_8n1();
        bit to;
        int d;
        cfg(16'd3, 2'b11, 1'b0, 1'b0, 1'b0);
        clr_mon();
        write(8'hA5);
        checks++;
        if (fifo_count !== 3'd1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL 8n1_wr_latency count=%0d tx=%b exp count 1 tx 1", fifo_count, tx);
        end
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0 || tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL 8n1_start count=%0d tx=%b busy=%b exp 0 0 1", fifo_count, tx, busy);
        end
        wait_done(1, 200, to);
        repeat (5) @(negedge clk);
        d = seq_diff(64'b0101001011, 10, 4);
        checks++;
        if (to || d !== 0) begin
            errors++;
            $display("FAIL 8n1_bits timeout=%0d diffs=%0d exp 0 0", to, d);
        end
        checks++;
        if (txq.size() !== 40 || done_cnt !== 1 || last_done - first_busy !== 40) begin
            errors++;
            $display("FAIL 8n1_timing busy=%0d done=%0d gap=%0d exp 40 1 40",
                     txq.size(), done_cnt, last_done - first_busy);
        end
    endtask

    task automatic test_7e2();
        bit to;
        int d;
        cfg(16'd3, 2'b10, 1'b1, 1'b0, 1'b1);
        clr_mon();
        write(8'h35);
        wait_done(1, 200, to);
        repeat (3) @(negedge clk);
        d = seq_diff(64'b01010110011, 11, 4);
        checks++;
        if (to || d !== 0 || last_done - first_busy !== 44) begin
            errors++;
            $display("FAIL 7e2_frame timeout=%0d diffs=%0d len=%0d exp 0 0 44",
                     to, d, last_done - first_busy);
        end
    endtask

    task automatic test_5o1();
        bit to;
        int d;
        cfg(16'd3, 2'b00, 1'b1, 1'b1, 1'b0);
        clr_mon();
        write(8'h1F);
        repeat (6) @(negedge clk);
        data_bits = 2'b11;
        stop2     = 1'b1;
        wait_done(1, 200, to);
        repeat (3) @(negedge clk);
        d = seq_diff(64'b01111101, 8, 4);
        checks++;
        if (to || d !== 0 || last_done - first_busy !== 32) begin
            errors++;
            $display("FAIL 5o1_frame timeout=%0d diffs=%0d len=%0d exp 0 0 32",
                     to, d, last_done - first_busy);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int d;
        cfg(16'd3, 2'b11, 1'b0, 1'b0, 1'b0);
        tx_en = 1'b0;
        clr_mon();
        write(8'h11); write(8'h22); write(8'h33); write(8'h44);
        checks++;
        if (fifo_count !== 3'd4 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full count=%0d ready=%b exp 4 0", fifo_count, wr_ready);
        end
        write(8'h55);
        checks++;
        if (fifo_count !== 3'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_when_full count=%0d busy=%b exp 4 0", fifo_count, busy);
        end
        tx_en = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd3 || tx !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_pop count=%0d tx=%b exp 3 0", fifo_count, tx);
        end
        wait_done(4, 400, to);
        repeat (5) @(negedge clk);
        d = seq_diff({10'b0100010001, 10'b0010001001, 10'b0110011001, 10'b0001000101}, 40, 4);
        checks++;
        if (to || d !== 0) begin
            errors++;
            $display("FAIL b2b_bits timeout=%0d diffs=%0d exp 0 0", to, d);
        end
        checks++;
        if (done_cnt !== 4 || last_done - first_busy !== 160) begin
            errors++;
            $display("FAIL b2b_timing done=%0d span=%0d exp 4 160", done_cnt, last_done - first_busy);
        end
        checks++;
        if (dcount_q.size() !== 4 || dcount_q[0] !== 2 || dcount_q[1] !== 1 ||
            dcount_q[2] !== 0 || dcount_q[3] !== 0) begin
            errors++;
            $display("FAIL b2b_count_at_done n=%0d first=%0d exp 4 entries 2,1,0,0",
                     dcount_q.size(), (dcount_q.size() > 0) ? dcount_q[0] : -1);
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        int d;
        cfg(16'd3, 2'b11, 1'b0, 1'b0, 1'b0);
        clr_mon();
        write(8'hA5);
        write(8'h77);
        repeat (13) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy busy=%b exp 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL midframe_reset tx=%b busy=%b count=%0d exp 1 0 0", tx, busy, fifo_count);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt !== 0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_done done=%0d tx=%b exp 0 1", done_cnt, tx);
        end
        clr_mon();
        write(8'h3C);
        wait_done(1, 200, to);
        repeat (3) @(negedge clk);
        d = seq_diff(64'b0001111001, 10, 4);
        checks++;
        if (to || d !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL after_reset_3c timeout=%0d diffs=%0d done=%0d exp 0 0 1", to, d, done_cnt);
        end
    endtask

    task automatic test_baud0();
        bit to;
        int d;
        cfg(16'd0, 2'b11, 1'b0, 1'b0, 1'b0);
        clr_mon();
        write(8'h81);
        wait_done(1, 100, to);
        repeat (3) @(negedge clk);
        d = seq_diff(64'b0100000011, 10, 1);
        checks++;
        if (to || d !== 0 || last_done - first_busy !== 10) begin
            errors++;
            $display("FAIL baud0_frame timeout=%0d diffs=%0d len=%0d exp 0 0 10",
                     to, d, last_done - first_busy);
        end
    endtask

    initial begin
        rst = 1'b1; tx_en = 1'b1; wr_valid = 1'b0; wr_data = '0;
        cfg(16'd3, 2'b11, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_8n1();
        test_7e2();
        test_5o1();
        test_back_to_back();
        test_reset_midframe();
        test_baud0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
